instruction_fetch_stage: RTL and testbench

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage_pkg.sv | 20 ++
 rtl/if_id_register.sv | 28 ++
 rtl/instruction_fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP word and PC constants.
package instruction_fetch_stage_pkg;

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      FETCH      = 2'd1,
      WAIT_MEM   = 2'd2,
      BUFFERED   = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP          = 32'b0;
   localparam logic [31:0] PC_INCREMENT = 32'd4;
   localparam logic [31:0] PC_RESET     = 32'h0;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: squash wins over load, otherwise contents hold.
module if_id_register
   import instruction_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        squash,
   input  logic [31:0] instruction,
   input  logic [31:0] next_pc,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_next_pc,
   output logic        if_id_valid
);

   always_ff @(posedge clk) begin
      if (reset || squash) begin
         if_id_instruction <= NOP;
         if_id_next_pc     <= '0;
         if_id_valid       <= 1'b0;
      end else if (load) begin
         if_id_instruction <= instruction;
         if_id_next_pc     <= next_pc;
         if_id_valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry stall buffer and IF/ID register.
// Optional stall cycle counter enabled by defining FETCH_STALL_COUNTER_EN.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_enable,
   input  logic        flush,
   input  logic        pc_source_select,
   input  logic [31:0] branch_target,
   output logic        instr_mem_request,
   output logic [31:0] instr_mem_address,
   input  logic [31:0] instr_mem_data,
   input  logic        instr_mem_ready,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_next_pc,
   output logic        if_id_valid
`ifdef FETCH_STALL_COUNTER_EN
   ,
   output logic [15:0] stall_cycle_count
`endif
);

   fetch_state_t state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] pc_plus;
   logic [31:0] target;
   logic [31:0] buf_word, buf_word_next;
   logic        pend, pend_next;
   logic [31:0] pend_pc, pend_pc_next;
   logic        load, squash;
   logic [31:0] load_word;

   assign pc_plus           = pc + PC_INCREMENT;
   assign target            = align_word(branch_target);
   assign instr_mem_address = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RESET_HOLD;
         pc       <= PC_RESET;
         buf_word <= NOP;
         pend     <= 1'b0;
         pend_pc  <= PC_RESET;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         buf_word <= buf_word_next;
         pend     <= pend_next;
         pend_pc  <= pend_pc_next;
      end
   end

   always_comb begin
      state_next        = state;
      pc_next           = pc;
      buf_word_next     = buf_word;
      pend_next         = pend;
      pend_pc_next      = pend_pc;
      instr_mem_request = 1'b0;
      load              = 1'b0;
      squash            = 1'b0;
      load_word         = instr_mem_data;
      case (state)
         RESET_HOLD: begin
            state_next = FETCH;
            if (pc_source_select) begin
               pc_next = target;
               squash  = 1'b1;
            end else if (flush) begin
               squash = 1'b1;
            end
         end
         FETCH: begin
            if (pc_source_select) begin
               pc_next = target;
               squash  = 1'b1;
            end else begin
               squash = flush;
               if (!stall_enable) begin
                  instr_mem_request = 1'b1;
                  if (instr_mem_ready) begin
                     load    = 1'b1;
                     pc_next = pc_plus;
                  end else begin
                     state_next = WAIT_MEM;
                  end
               end
            end
         end
         WAIT_MEM: begin
            // The outstanding fetch must complete at a stable address; a redirect
            // seen meanwhile is parked in pend/pend_pc and the word is discarded.
            instr_mem_request = 1'b1;
            if (pc_source_select) begin
               squash = 1'b1;
               if (instr_mem_ready) begin
                  pc_next    = target;
                  pend_next  = 1'b0;
                  state_next = FETCH;
               end else begin
                  pend_next    = 1'b1;
                  pend_pc_next = target;
               end
            end else if (pend) begin
               squash = flush;
               if (instr_mem_ready) begin
                  pc_next    = pend_pc;
                  pend_next  = 1'b0;
                  state_next = FETCH;
               end
            end else begin
               squash = flush;
               if (instr_mem_ready) begin
                  if (flush) begin
                     pc_next    = pc_plus;
                     state_next = FETCH;
                  end else if (stall_enable) begin
                     buf_word_next = instr_mem_data;
                     state_next    = BUFFERED;
                  end else begin
                     load       = 1'b1;
                     pc_next    = pc_plus;
                     state_next = FETCH;
                  end
               end
            end
         end
         BUFFERED: begin
            if (pc_source_select) begin
               pc_next       = target;
               squash        = 1'b1;
               buf_word_next = NOP;
               state_next    = FETCH;
            end else if (flush) begin
               squash        = 1'b1;
               buf_word_next = NOP;
               pc_next       = pc_plus;
               state_next    = FETCH;
            end else if (!stall_enable) begin
               load          = 1'b1;
               load_word     = buf_word;
               buf_word_next = NOP;
               pc_next       = pc_plus;
               state_next    = FETCH;
            end
         end
         default: state_next = RESET_HOLD;
      endcase
   end

   if_id_register u_if_id (
      .clk               (clk),
      .reset             (reset),
      .load              (load),
      .squash            (squash),
      .instruction       (load_word),
      .next_pc           (pc_plus),
      .if_id_instruction (if_id_instruction),
      .if_id_next_pc     (if_id_next_pc),
      .if_id_valid       (if_id_valid)
   );

`ifdef FETCH_STALL_COUNTER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycle_count <= '0;
      end else if (stall_enable && (stall_cycle_count != 16'hFFFF)) begin
         stall_cycle_count <= stall_cycle_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage (stall counter checks need FETCH_STALL_COUNTER_EN).
module tb_instruction_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_enable;
   logic        flush;
   logic        pc_source_select;
   logic [31:0] branch_target;
   logic        instr_mem_request;
   logic [31:0] instr_mem_address;
   logic [31:0] instr_mem_data;
   logic        instr_mem_ready;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_next_pc;
   logic        if_id_valid;
`ifdef FETCH_STALL_COUNTER_EN
   logic [15:0] stall_cycle_count;
`endif

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] WORD_C = 32'h1111_0004;

   instruction_fetch_stage dut (
      .clk               (clk),
      .reset             (reset),
      .stall_enable      (stall_enable),
      .flush             (flush),
      .pc_source_select  (pc_source_select),
      .branch_target     (branch_target),
      .instr_mem_request (instr_mem_request),
      .instr_mem_address (instr_mem_address),
      .instr_mem_data    (instr_mem_data),
      .instr_mem_ready   (instr_mem_ready),
      .if_id_instruction (if_id_instruction),
      .if_id_next_pc     (if_id_next_pc),
      .if_id_valid       (if_id_valid)
`ifdef FETCH_STALL_COUNTER_EN
      ,
      .stall_cycle_count (stall_cycle_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in RESET_HOLD with reset released and all inputs idle.
   task automatic do_reset();
      reset = 1'b1; stall_enable = 1'b0; flush = 1'b0; pc_source_select = 1'b0;
      branch_target = '0; instr_mem_data = '0; instr_mem_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Reset, then two single-cycle fetches of WORD_C: PC=8, state FETCH, IF/ID next_pc=8.
   task automatic to_pc8();
      do_reset();
      instr_mem_ready = 1'b1; instr_mem_data = WORD_C;
      tick(); tick(); tick();
      instr_mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_enable = 1'b0; flush = 1'b0; pc_source_select = 1'b0;
      branch_target = '0; instr_mem_data = 32'hFFFF_FFFF; instr_mem_ready = 1'b1;
      tick(); tick();
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_next_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_ifid: valid=%b instr=%h next_pc=%h required 0/0/0", if_id_valid, if_id_instruction, if_id_next_pc);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (instr_mem_request !== 1'b0 || instr_mem_address !== 32'h0) begin
         failures++;
         $display("FAIL reset_hold: req=%b addr=%h required 0/00000000", instr_mem_request, instr_mem_address);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      instr_mem_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         instr_mem_data = 32'hA000_0000 + i;
         #1;
         checks++;
         if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'(4 * i)) begin
            failures++;
            $display("FAIL seq_addr%0d: req=%b addr=%h required 1/%h", i, instr_mem_request, instr_mem_address, 32'(4 * i));
         end
         tick();
         checks++;
         if (if_id_next_pc !== 32'(4 * (i + 1)) || if_id_instruction !== 32'hA000_0000 + i || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_ifid%0d: next_pc=%h instr=%h valid=%b required %h/%h/1", i, if_id_next_pc,
                     if_id_instruction, if_id_valid, 32'(4 * (i + 1)), 32'hA000_0000 + i);
         end
      end
      instr_mem_ready = 1'b0;
   endtask

   task automatic test_wait_mem();
      to_pc8();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'h8 || if_id_next_pc !== 32'h8) begin
            failures++;
            $display("FAIL wait_hold%0d: req=%b addr=%h ifid_next_pc=%h required 1/8/8", i, instr_mem_request, instr_mem_address, if_id_next_pc);
         end
         tick();
      end
      instr_mem_ready = 1'b1; instr_mem_data = 32'h0BAD_F00D;
      tick();
      checks++;
      if (if_id_instruction !== 32'h0BAD_F00D || if_id_next_pc !== 32'hC || if_id_valid !== 1'b1) begin
         failures++;
         $display("FAIL wait_load: instr=%h next_pc=%h valid=%b required 0badf00d/c/1", if_id_instruction, if_id_next_pc, if_id_valid);
      end
      instr_mem_ready = 1'b0;
      #1;
      checks++;
      if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'hC) begin
         failures++;
         $display("FAIL wait_next: req=%b addr=%h required 1/c", instr_mem_request, instr_mem_address);
      end
   endtask

   task automatic test_buffered();
      to_pc8();
      tick();
      stall_enable = 1'b1; instr_mem_ready = 1'b1; instr_mem_data = 32'hB0B0_B0B0;
      #1;
      checks++;
      if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'h8) begin
         failures++;
         $display("FAIL buf_wait_req: req=%b addr=%h required 1/8", instr_mem_request, instr_mem_address);
      end
      tick();
      instr_mem_ready = 1'b0; instr_mem_data = 32'h0;
      tick();
      checks++;
      if (instr_mem_request !== 1'b0 || if_id_instruction !== WORD_C || if_id_next_pc !== 32'h8) begin
         failures++;
         $display("FAIL buf_hold: req=%b instr=%h next_pc=%h required 0/%h/8", instr_mem_request, if_id_instruction, if_id_next_pc, WORD_C);
      end
      stall_enable = 1'b0;
      tick();
      checks++;
      if (if_id_instruction !== 32'hB0B0_B0B0 || if_id_next_pc !== 32'hC || if_id_valid !== 1'b1) begin
         failures++;
         $display("FAIL buf_release: instr=%h next_pc=%h valid=%b required b0b0b0b0/c/1", if_id_instruction, if_id_next_pc, if_id_valid);
      end
      checks++;
      if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'hC) begin
         failures++;
         $display("FAIL buf_next: req=%b addr=%h required 1/c", instr_mem_request, instr_mem_address);
      end
   endtask

   task automatic test_redirect();
      to_pc8();
      tick();
      pc_source_select = 1'b1; branch_target = 32'h0000_0103;
      tick();
      pc_source_select = 1'b0; branch_target = '0;
      checks++;
      if (if_id_instruction !== 32'h0 || if_id_valid !== 1'b0 || instr_mem_request !== 1'b1 || instr_mem_address !== 32'h8) begin
         failures++;
         $display("FAIL redir_pending: instr=%h valid=%b req=%b addr=%h required 0/0/1/8", if_id_instruction, if_id_valid,
                  instr_mem_request, instr_mem_address);
      end
      instr_mem_ready = 1'b1; instr_mem_data = 32'hDEAD_DEAD;
      tick();
      instr_mem_ready = 1'b0;
      #1;
      checks++;
      if (if_id_instruction !== 32'h0 || if_id_valid !== 1'b0 || instr_mem_request !== 1'b1 || instr_mem_address !== 32'h100) begin
         failures++;
         $display("FAIL redir_target: instr=%h valid=%b req=%b addr=%h required 0/0/1/100", if_id_instruction, if_id_valid,
                  instr_mem_request, instr_mem_address);
      end
   endtask

   task automatic test_flush();
      to_pc8();
      flush = 1'b1; stall_enable = 1'b1;
      tick();
      flush = 1'b0; stall_enable = 1'b0;
      #1;
      checks++;
      if (if_id_instruction !== 32'h0 || if_id_valid !== 1'b0 || instr_mem_address !== 32'h8) begin
         failures++;
         $display("FAIL flush: instr=%h valid=%b addr=%h required 0/0/8", if_id_instruction, if_id_valid, instr_mem_address);
      end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      tick();
      pc_source_select = 1'b1; branch_target = 32'hFFFF_FFFF;
      tick();
      pc_source_select = 1'b0;
      instr_mem_ready = 1'b1; instr_mem_data = 32'h5555_AAAA;
      #1;
      checks++;
      if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_addr: req=%b addr=%h required 1/fffffffc", instr_mem_request, instr_mem_address);
      end
      tick();
      instr_mem_ready = 1'b0;
      #1;
      checks++;
      if (if_id_next_pc !== 32'h0 || if_id_instruction !== 32'h5555_AAAA || instr_mem_address !== 32'h0) begin
         failures++;
         $display("FAIL wrap_next: next_pc=%h instr=%h addr=%h required 0/5555aaaa/0", if_id_next_pc, if_id_instruction, instr_mem_address);
      end
      instr_mem_ready = 1'b1; instr_mem_data = 32'h1234_5678;
      tick();
      instr_mem_ready = 1'b0;
      tick();
      checks++;
      if (instr_mem_request !== 1'b1 || instr_mem_address !== 32'h4) begin
         failures++;
         $display("FAIL rst_pre: req=%b addr=%h required 1/4", instr_mem_request, instr_mem_address);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; instr_mem_ready = 1'b1; instr_mem_data = 32'hBAD0_BAD0;
      #1;
      checks++;
      if (instr_mem_request !== 1'b0 || instr_mem_address !== 32'h0 || if_id_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_wait: req=%b addr=%h valid=%b required 0/0/0", instr_mem_request, instr_mem_address, if_id_valid);
      end
      tick();
      instr_mem_ready = 1'b0;
      #1;
      checks++;
      if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || instr_mem_request !== 1'b1 || instr_mem_address !== 32'h0) begin
         failures++;
         $display("FAIL rst_late_ready: valid=%b instr=%h req=%b addr=%h required 0/0/1/0", if_id_valid, if_id_instruction,
                  instr_mem_request, instr_mem_address);
      end
   endtask

`ifdef FETCH_STALL_COUNTER_EN
   task automatic test_stall_counter();
      reset = 1'b1; stall_enable = 1'b1;
      tick(); tick();
      checks++;
      if (stall_cycle_count !== 16'h0) begin
         failures++;
         $display("FAIL cnt_reset: count=%h required 0000", stall_cycle_count);
      end
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (stall_cycle_count !== 16'd3) begin
         failures++;
         $display("FAIL cnt_three: count=%h required 0003", stall_cycle_count);
      end
      repeat (70000 - 3) tick();
      checks++;
      if (stall_cycle_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL cnt_saturate: count=%h required ffff", stall_cycle_count);
      end
      stall_enable = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_wait_mem();
      test_buffered();
      test_redirect();
      test_flush();
      test_wrap_and_reset();
`ifdef FETCH_STALL_COUNTER_EN
      test_stall_counter();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
